// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register slave: FSM encoding, register map
// bases and frame geometry.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEVID,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_SKIP
  } state_e;

  localparam logic [7:0] ADDR_ID   = 8'h00;
  localparam logic [7:0] FREQ_BASE = 8'h10;
  localparam logic [7:0] DUTY_BASE = 8'h20;

  localparam int RW_BIT    = 0;
  localparam int HDR_BITS  = 8;
  localparam int WORD_BITS = 16;

  localparam logic [3:0] HDR_LAST  = 4'(HDR_BITS - 1);
  localparam logic [3:0] WORD_LAST = 4'(WORD_BITS - 1);

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus a third stage that
// yields registered single-clock rise/fall pulses aligned with level_o.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {3{RST_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign level_o = sync_q[2];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: device byte, address byte, then 16-bit data words
// with burst auto-increment, driving the PWM channel frequency/duty registers.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned FREQ_W   = 16,
  parameter int unsigned DUTY_W   = 7,
  parameter logic [6:0]  DEV_ID   = 7'h32,
  parameter int unsigned FREQ_RST = 100,
  parameter int unsigned DUTY_RST = 50,
  parameter logic [7:0]  VERSION  = 8'h02
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ss,
  input  logic                    sck,
  input  logic                    mosi,
  output logic                    miso,
  output logic [NCH*FREQ_W-1:0]   pwm_freq,
  output logic [NCH*DUTY_W-1:0]   pwm_duty,
  output logic                    reg_wr,
  output logic [7:0]              reg_wr_addr,
  output logic                    frame_err
);

  localparam logic [FREQ_W-1:0] FREQ_RST_V = FREQ_W'(FREQ_RST);
  localparam logic [DUTY_W-1:0] DUTY_RST_V = DUTY_W'(DUTY_RST);

  logic ss_lvl, ss_rise, ss_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // ss idles high so that releasing reset never fakes a frame start.
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset(reset), .d_i(ss),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset(reset), .d_i(sck),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .d_i(mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, ss_lvl, sck_lvl, mosi_rise, mosi_fall};

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sh_q, sh_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        is_read_q, is_read_d;
  logic        miso_q, miso_d;
  logic        frame_err_q, frame_err_d;

  logic [FREQ_W-1:0] freq_q [NCH];
  logic [DUTY_W-1:0] duty_q [NCH];
  logic              reg_wr_q;
  logic [7:0]        reg_wr_addr_q;

  logic [15:0] shift_in;
  logic [7:0]  hdr_byte;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_en;
  logic        wr_hit;

  assign shift_in = {sh_q[14:0], mosi_lvl};
  assign hdr_byte = shift_in[7:0];
  // The address phase reads the byte being completed; data phases prefetch ahead.
  assign rd_addr  = (state_q == ST_ADDR) ? hdr_byte : ptr_q + 8'd1;

  always_comb begin
    rd_data = '0;
    if (rd_addr == ADDR_ID) rd_data = {8'h00, VERSION};
    for (int i = 0; i < NCH; i++) begin
      if (rd_addr == FREQ_BASE + 8'(i)) rd_data = 16'(freq_q[i]);
      if (rd_addr == DUTY_BASE + 8'(i)) rd_data = 16'(duty_q[i]);
    end
  end

  always_comb begin
    wr_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ptr_q == FREQ_BASE + 8'(i) || ptr_q == DUTY_BASE + 8'(i)) wr_hit = wr_en;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    is_read_d   = is_read_q;
    miso_d      = 1'b0;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_DEVID;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
      ST_DEVID: begin
        if (sck_rise) begin
          sh_d  = shift_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            if (hdr_byte[7:1] == DEV_ID) begin
              state_d   = ST_ADDR;
              is_read_d = hdr_byte[RW_BIT];
            end else begin
              state_d     = ST_SKIP;
              frame_err_d = 1'b1;
            end
          end
        end
      end
      ST_ADDR: begin
        if (sck_rise) begin
          sh_d  = shift_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            ptr_d = hdr_byte;
            if (is_read_q) begin
              state_d = ST_RDATA;
              sh_d    = rd_data;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
      end
      ST_WDATA: begin
        if (sck_rise) begin
          sh_d  = shift_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == WORD_LAST) begin
            cnt_d = '0;
            wr_en = 1'b1;
            ptr_d = ptr_q + 8'd1;
          end
        end
      end
      ST_RDATA: begin
        miso_d = miso_q;
        if (sck_fall) begin
          miso_d = sh_q[15];
          sh_d   = {sh_q[14:0], 1'b0};
        end
        if (sck_rise) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == WORD_LAST) begin
            cnt_d = '0;
            sh_d  = rd_data;
            ptr_d = ptr_q + 8'd1;
          end
        end
      end
      ST_SKIP: ;
      default: state_d = ST_IDLE;
    endcase

    // A word finishing in the same clock as ss rises has already committed above.
    if (ss_rise && state_q != ST_IDLE) begin
      if ((state_d inside {ST_DEVID, ST_ADDR}) ||
          ((state_d inside {ST_WDATA, ST_RDATA}) && cnt_d != 4'd0)) begin
        frame_err_d = 1'b1;
      end
      state_d = ST_IDLE;
      miso_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      is_read_q   <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      is_read_q   <= is_read_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: the channel bank is a set of configuration flops, not a RAM, so it
  // is reset to usable PWM defaults rather than left undefined.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        freq_q[i] <= FREQ_RST_V;
        duty_q[i] <= DUTY_RST_V;
      end
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= '0;
    end else begin
      reg_wr_q <= wr_hit;
      if (wr_hit) reg_wr_addr_q <= ptr_q;
      if (wr_en) begin
        for (int i = 0; i < NCH; i++) begin
          if (ptr_q == FREQ_BASE + 8'(i)) freq_q[i] <= shift_in[FREQ_W-1:0];
          if (ptr_q == DUTY_BASE + 8'(i)) duty_q[i] <= shift_in[DUTY_W-1:0];
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_out
    assign pwm_freq[i*FREQ_W +: FREQ_W] = freq_q[i];
    assign pwm_duty[i*DUTY_W +: DUTY_W] = duty_q[i];
  end

  assign miso        = miso_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: drives SPI mode-0 frames from the pins and
// checks registers, pulses and read-back against hand-computed values.
module tb_spi_reg_slave;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        ss;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic [63:0] pwm_freq;
  logic [27:0] pwm_duty;
  logic        reg_wr;
  logic [7:0]  reg_wr_addr;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int wr_pulses = 0;
  int ferr_pulses = 0;
  int wr_base;
  int ferr_base;
  logic [15:0] rx;

  spi_reg_slave dut (
    .clock(clock), .reset(reset), .ss(ss), .sck(sck), .mosi(mosi),
    .miso(miso), .pwm_freq(pwm_freq), .pwm_duty(pwm_duty),
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reg_wr === 1'b1) wr_pulses++;
    if (frame_err === 1'b1) ferr_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Shifts n bits of tx MSB first; miso is captured just before each sck rise.
  task automatic spi_bits(input logic [15:0] tx, input int n, input bit ss_on_last,
                          output logic [15:0] rx_o);
    rx_o = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      rx_o = {rx_o[14:0], miso};
      sck = 1'b1;
      if (ss_on_last && i == 0) ss = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [15:0] dummy;
    spi_bits({8'h00, b}, 8, 1'b0, dummy);
  endtask

  task automatic frame_start();
    ss = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    ss = 1'b1;
    mosi = 1'b0;
    wait_clk(4 * HALF);
  endtask

  task automatic write1(input logic [7:0] addr, input logic [15:0] data);
    logic [15:0] dummy;
    frame_start();
    send_byte(8'h64);
    send_byte(addr);
    spi_bits(data, 16, 1'b0, dummy);
    frame_end();
  endtask

  task automatic read1(input logic [7:0] addr, output logic [15:0] data);
    frame_start();
    send_byte(8'h65);
    send_byte(addr);
    spi_bits(16'h0000, 16, 1'b0, data);
    frame_end();
  endtask

  initial begin
    reset = 1'b0;
    ss    = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    wait_clk(5);
    reset = 1'b1;
    wait_clk(5);

    check("rst_freq", pwm_freq, {4{16'd100}});
    check("rst_duty", pwm_duty, {4{7'd50}});
    check("rst_miso", miso, 1'b0);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_wr_addr", reg_wr_addr, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);

    // Burst read of the frequency bank straight after reset.
    ferr_base = ferr_pulses;
    frame_start();
    send_byte(8'h65);
    send_byte(8'h10);
    spi_bits(16'h0000, 16, 1'b0, rx); check("rd_f0", rx, 16'h0064);
    spi_bits(16'h0000, 16, 1'b0, rx); check("rd_f1", rx, 16'h0064);
    spi_bits(16'h0000, 16, 1'b0, rx); check("rd_f2", rx, 16'h0064);
    frame_end();
    read1(8'h00, rx); check("rd_id", rx, 16'h0002);

    // Pointer wrap: 0xFF is unmapped, then 0x00 is the ID register.
    frame_start();
    send_byte(8'h65);
    send_byte(8'hFF);
    spi_bits(16'h0000, 16, 1'b0, rx); check("rd_wrap_ff", rx, 16'h0000);
    spi_bits(16'h0000, 16, 1'b0, rx); check("rd_wrap_00", rx, 16'h0002);
    frame_end();
    check("rd_no_ferr", ferr_pulses - ferr_base, 0);

    wr_base = wr_pulses;
    write1(8'h12, 16'h1234);
    check("wr_freq2", pwm_freq, {16'h0064, 16'h1234, 16'h0064, 16'h0064});
    check("wr_freq2_pulses", wr_pulses - wr_base, 1);
    check("wr_freq2_addr", reg_wr_addr, 8'h12);

    wr_base = wr_pulses;
    frame_start();
    send_byte(8'h64);
    send_byte(8'h20);
    spi_bits(16'h0011, 16, 1'b0, rx);
    spi_bits(16'h0022, 16, 1'b0, rx);
    spi_bits(16'h0033, 16, 1'b0, rx);
    spi_bits(16'h0044, 16, 1'b0, rx);
    frame_end();
    check("burst_duty", pwm_duty, {7'h44, 7'h33, 7'h22, 7'h11});
    check("burst_pulses", wr_pulses - wr_base, 4);
    check("burst_addr", reg_wr_addr, 8'h23);
    check("burst_no_ferr", ferr_pulses - ferr_base, 0);

    frame_start();
    send_byte(8'h65);
    send_byte(8'h12);
    spi_bits(16'h0000, 16, 1'b0, rx); check("rdback_12", rx, 16'h1234);
    spi_bits(16'h0000, 16, 1'b0, rx); check("rdback_13", rx, 16'h0064);
    frame_end();
    read1(8'h22, rx); check("rdback_22", rx, 16'h0033);

    // Wrong device ID: the rest of the frame must be ignored.
    wr_base = wr_pulses;
    ferr_base = ferr_pulses;
    frame_start();
    send_byte(8'h66);
    send_byte(8'h12);
    spi_bits(16'hFFFF, 16, 1'b0, rx);
    frame_end();
    check("badid_miso", rx, 16'h0000);
    check("badid_ferr", ferr_pulses - ferr_base, 1);
    check("badid_no_wr", wr_pulses - wr_base, 0);
    check("badid_freq", pwm_freq, {16'h0064, 16'h1234, 16'h0064, 16'h0064});

    write1(8'h13, 16'hBEEF);
    check("after_badid_freq", pwm_freq, {16'hBEEF, 16'h1234, 16'h0064, 16'h0064});
    check("after_badid_addr", reg_wr_addr, 8'h13);

    // Frame aborted after 9 data bits.
    wr_base = wr_pulses;
    ferr_base = ferr_pulses;
    frame_start();
    send_byte(8'h64);
    send_byte(8'h21);
    spi_bits(16'h01FF, 9, 1'b0, rx);
    frame_end();
    check("partial_duty", pwm_duty, {7'h44, 7'h33, 7'h22, 7'h11});
    check("partial_ferr", ferr_pulses - ferr_base, 1);
    check("partial_no_wr", wr_pulses - wr_base, 0);

    wr_base = wr_pulses;
    ferr_base = ferr_pulses;
    write1(8'h7F, 16'h5555);
    check("unmapped_no_wr", wr_pulses - wr_base, 0);
    check("unmapped_addr", reg_wr_addr, 8'h13);
    check("unmapped_ferr", ferr_pulses - ferr_base, 0);
    read1(8'h7F, rx); check("unmapped_rd", rx, 16'h0000);

    // ss rises together with the 16th sck rise: word commits, clean end.
    wr_base = wr_pulses;
    ferr_base = ferr_pulses;
    frame_start();
    send_byte(8'h64);
    send_byte(8'h23);
    spi_bits(16'h007E, 16, 1'b1, rx);
    frame_end();
    check("edge_duty", pwm_duty, {7'h7E, 7'h33, 7'h22, 7'h11});
    check("edge_pulses", wr_pulses - wr_base, 1);
    check("edge_ferr", ferr_pulses - ferr_base, 0);
    check("edge_addr", reg_wr_addr, 8'h23);

    // Reset in the middle of a burst write, after one word has committed.
    frame_start();
    send_byte(8'h64);
    send_byte(8'h10);
    spi_bits(16'hAAAA, 16, 1'b0, rx);
    spi_bits(16'h00FF, 8, 1'b0, rx);
    check("midrst_pre_freq0", pwm_freq[15:0], 16'hAAAA);
    reset = 1'b0;
    wait_clk(3);
    ss = 1'b1;
    mosi = 1'b0;
    wait_clk(3);
    check("midrst_freq", pwm_freq, {4{16'd100}});
    check("midrst_duty", pwm_duty, {4{7'd50}});
    check("midrst_addr", reg_wr_addr, 8'h00);
    check("midrst_miso", miso, 1'b0);
    check("midrst_reg_wr", reg_wr, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    reset = 1'b1;
    wait_clk(10);

    wr_base = wr_pulses;
    ferr_base = ferr_pulses;
    write1(8'h11, 16'h0777);
    check("postrst_freq", pwm_freq, {16'h0064, 16'h0064, 16'h0777, 16'h0064});
    check("postrst_pulses", wr_pulses - wr_base, 1);
    check("postrst_ferr", ferr_pulses - ferr_base, 0);
    read1(8'h11, rx); check("postrst_rd", rx, 16'h0777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
